// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
//   Responder end of an HD44780-style 8-bit text-LCD write bus. It decodes
//   rs/rw/data transfers, keeps a 2x16 shadow DDRAM with its address counter
//   (AC) and display flags, and presents the visible text as two packed
//   16-character lines (char 0 in bits [127:120]).
//
//   Optional feature: define LCD_READ_EN to service busy-flag/AC reads and
//   data reads. Without it every rw=1 transfer is ignored (or counted as a
//   drop while busy) and rd_data/rd_oe stay 0.
//
// Ports
//   clk_100hz    bus clock, at most one transfer per cycle
//   rst          asynchronous, active-low reset
//   bus_valid    transfer strobe, bus sampled on posedge when high
//   lcd_rs       0 = instruction, 1 = data
//   lcd_rw       0 = write, 1 = read
//   lcd_data     write payload
//   rd_data      read response, valid while rd_oe is high
//   rd_oe        one-cycle read-response strobe
//   line1_text   row 0 text
//   line2_text   row 1 text
//   cursor_addr  address counter AC
//   display_on, cursor_on, blink_on   display control D/C/B
//   inc_mode     entry-mode I/D
//   init_done    set by the first function-set instruction
//   busy         clear-display sweep or settle time in progress
//   drop_cnt     transfers ignored while busy, saturating at 255
module lcd_bus_responder #(
  parameter logic [7:0]  BLANK_CHAR = 8'h20,
  parameter int unsigned CLEAR_WAIT = 4
) (
  input  logic         clk_100hz,
  input  logic         rst,
  input  logic         bus_valid,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic [7:0]   lcd_data,
  output logic [7:0]   rd_data,
  output logic         rd_oe,
  output logic [127:0] line1_text,
  output logic [127:0] line2_text,
  output logic [6:0]   cursor_addr,
  output logic         display_on,
  output logic         cursor_on,
  output logic         blink_on,
  output logic         inc_mode,
  output logic         init_done,
  output logic         busy,
  output logic [7:0]   drop_cnt
);

`ifdef LCD_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [3:0] WAIT_LAST = 4'(CLEAR_WAIT - 1);

  logic [1:0] state;
  logic [4:0] clr_idx;
  logic [3:0] wait_cnt;
  logic       cg_mode;
  logic [6:0] ac;
  logic [7:0] row0 [16];
  logic [7:0] row1 [16];
  logic [7:0] cell_rd;

  // AC walks 0x00..0x27 then 0x40..0x67, wrapping between the two windows.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h00)      return 7'h67;
      else if (a == 7'h40) return 7'h27;
      else                 return a - 7'd1;
    end
  endfunction

  // Addresses in the gaps between the two windows snap to the next window start.
  function automatic logic [6:0] ac_remap(input logic [6:0] a);
    if (a >= 7'h28 && a <= 7'h3F)      return 7'h40;
    else if (a >= 7'h68)               return 7'h00;
    else                               return a;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    cell_rd = BLANK_CHAR;
    if (ac[5:4] == 2'b00) cell_rd = ac[6] ? row1[ac[3:0]] : row0[ac[3:0]];
  end

  // NOTE: all state below is sequential and uses non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      clr_idx     <= '0;
      wait_cnt    <= '0;
      cg_mode     <= 1'b0;
      ac          <= '0;
      inc_mode    <= 1'b1;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      init_done   <= 1'b0;
      rd_data     <= '0;
      rd_oe       <= 1'b0;
      drop_cnt    <= '0;
      // NOTE: the shadow DDRAM is reset on purpose: the mirrored text must be
      // blank immediately after reset, not after a clear sweep.
      for (int i = 0; i < 16; i++) begin
        row0[i] <= BLANK_CHAR;
        row1[i] <= BLANK_CHAR;
      end
    end else begin
      rd_oe <= 1'b0;

      case (state)
        S_CLEAR: begin
          if (clr_idx[4]) row1[clr_idx[3:0]] <= BLANK_CHAR;
          else            row0[clr_idx[3:0]] <= BLANK_CHAR;
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) begin
            wait_cnt <= '0;
            state    <= (CLEAR_WAIT == 0) ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_IDLE;
          else                       wait_cnt <= wait_cnt + 4'd1;
        end
        default: ;
      endcase

      if (bus_valid) begin
        if (busy) begin
          // Busy-flag reads stay serviced during a clear; all else is dropped.
          if (READ_EN && lcd_rw && !lcd_rs) begin
            rd_data <= {1'b1, ac};
            rd_oe   <= 1'b1;
          end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end else if (!lcd_rw) begin
          if (!lcd_rs) begin
            // Highest set bit selects the instruction.
            casez (lcd_data)
              8'b1???????: begin
                ac      <= ac_remap(lcd_data[6:0]);
                cg_mode <= 1'b0;
              end
              8'b01??????: cg_mode   <= 1'b1;
              8'b001?????: init_done <= 1'b1;
              8'b0001????: if (!lcd_data[3]) ac <= ac_step(ac, lcd_data[2]);
              8'b00001???: {display_on, cursor_on, blink_on} <= lcd_data[2:0];
              8'b000001??: inc_mode  <= lcd_data[1];
              8'b0000001?: ac        <= '0;
              8'b00000001: begin
                ac       <= '0;
                inc_mode <= 1'b1;
                cg_mode  <= 1'b0;
                clr_idx  <= '0;
                state    <= S_CLEAR;
              end
              default: ;
            endcase
          end else if (!cg_mode) begin
            // Only the 16 visible columns of each row are stored.
            if (ac[5:4] == 2'b00) begin
              if (ac[6]) row1[ac[3:0]] <= lcd_data;
              else       row0[ac[3:0]] <= lcd_data;
            end
            ac <= ac_step(ac, inc_mode);
          end
        end else if (READ_EN) begin
          rd_oe <= 1'b1;
          if (!lcd_rs) begin
            rd_data <= {1'b0, ac};
          end else begin
            rd_data <= cell_rd;
            if (!cg_mode) ac <= ac_step(ac, inc_mode);
          end
        end
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign cursor_addr = ac;

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign line1_text[127 - 8*g -: 8] = row0[g];
    assign line2_text[127 - 8*g -: 8] = row1[g];
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder
//   Scoreboard bench for lcd_bus_responder (default parameters). The driver
//   issues bus transfers and pushes expected observations into queues; the
//   monitor pops and compares on the falling clock edge: state checks every
//   negedge, read responses whenever rd_oe is high, and clear busy-run lengths
//   whenever busy falls.
module tb_lcd_bus_responder;

  typedef enum int {
    SIG_LINE1, SIG_LINE2, SIG_CURSOR, SIG_FLAGS, SIG_DROP, SIG_BUSY,
    SIG_RD_OE, SIG_RD_DATA, SIG_TIMEOUT, SIG_PENDING
  } sig_e;

  typedef struct {
    string        name;
    sig_e         sel;
    logic [127:0] val;
  } exp_t;

  logic         clk_100hz = 1'b0;
  logic         rst = 1'b0;
  logic         bus_valid = 1'b0;
  logic         lcd_rs = 1'b0;
  logic         lcd_rw = 1'b0;
  logic [7:0]   lcd_data = 8'h00;
  logic [7:0]   rd_data;
  logic         rd_oe;
  logic [127:0] line1_text;
  logic [127:0] line2_text;
  logic [6:0]   cursor_addr;
  logic         display_on, cursor_on, blink_on, inc_mode, init_done, busy;
  logic [7:0]   drop_cnt;

  exp_t         exp_q[$];
  logic [7:0]   rd_q[$];
  int           busy_q[$];
  int           n_vec = 0;
  int           n_fail = 0;
  int           busy_run = 0;
  logic         to_flag = 1'b0;
  exp_t         e;

  lcd_bus_responder dut (
    .clk_100hz  (clk_100hz),
    .rst        (rst),
    .bus_valid  (bus_valid),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_data   (lcd_data),
    .rd_data    (rd_data),
    .rd_oe      (rd_oe),
    .line1_text (line1_text),
    .line2_text (line2_text),
    .cursor_addr(cursor_addr),
    .display_on (display_on),
    .cursor_on  (cursor_on),
    .blink_on   (blink_on),
    .inc_mode   (inc_mode),
    .init_done  (init_done),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk_100hz = ~clk_100hz;

  // Packs a string into the 16-char line format, padding with spaces.
  function automatic logic [127:0] line_of(input string s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127 - 8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    return r;
  endfunction

  function automatic logic [127:0] observe(input sig_e sel);
    case (sel)
      SIG_LINE1:   return line1_text;
      SIG_LINE2:   return line2_text;
      SIG_CURSOR:  return 128'(cursor_addr);
      SIG_FLAGS:   return 128'({init_done, display_on, cursor_on, blink_on, inc_mode});
      SIG_DROP:    return 128'(drop_cnt);
      SIG_BUSY:    return 128'(busy);
      SIG_RD_OE:   return 128'(rd_oe);
      SIG_RD_DATA: return 128'(rd_data);
      SIG_TIMEOUT: return 128'(to_flag);
      SIG_PENDING: return 128'(rd_q.size() + busy_q.size());
      default:     return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk_100hz) begin
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, observe(e.sel), e.val);
    end
    if (rd_oe) begin
      if (rd_q.size() == 0) check("rd_oe_unexpected", 128'(rd_oe), 128'd0);
      else                  check("rd_data", 128'(rd_data), 128'(rd_q.pop_front()));
    end
    if (!rst) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      if (busy_q.size() == 0) check("busy_unexpected", 128'(busy_run), 128'd0);
      else                    check("busy_len", 128'(busy_run), 128'(busy_q.pop_front()));
      busy_run = 0;
    end
  end

  task automatic expect_sig(input string name, input sig_e sel, input logic [127:0] v);
    exp_q.push_back('{name, sel, v});
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
    bus_valid = 1'b1;
    lcd_rs    = rs;
    lcd_rw    = rw;
    lcd_data  = d;
    @(posedge clk_100hz);
    #1;
    bus_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk_100hz);
      #1;
      n++;
    end
    if (n >= 200) to_flag = 1'b1;
  endtask

  task automatic expect_reset_state(input string tag);
    expect_sig({tag, "_line1"},  SIG_LINE1,   line_of(""));
    expect_sig({tag, "_line2"},  SIG_LINE2,   line_of(""));
    expect_sig({tag, "_cursor"}, SIG_CURSOR,  128'h00);
    expect_sig({tag, "_flags"},  SIG_FLAGS,   128'b00001);
    expect_sig({tag, "_drop"},   SIG_DROP,    128'd0);
    expect_sig({tag, "_busy"},   SIG_BUSY,    128'd0);
    expect_sig({tag, "_rd_oe"},  SIG_RD_OE,   128'd0);
    expect_sig({tag, "_rd_data"},SIG_RD_DATA, 128'd0);
  endtask

  initial begin
    string cola;
    string fill;
    cola = "COLA";
    fill = "abcdefghijklmnop";

    // Reset state.
    expect_reset_state("reset");
    repeat (2) @(posedge clk_100hz);
    #1 rst = 1'b1;

    // Init sequence: function set, display on/cursor/blink, entry increment.
    xfer(0, 0, 8'h38);
    xfer(0, 0, 8'h0F);
    xfer(0, 0, 8'h06);
    expect_sig("init_flags", SIG_FLAGS, 128'b11111);
    expect_sig("init_line1", SIG_LINE1, line_of(""));

    // Row 0 text and row 1 first char.
    xfer(0, 0, 8'h80);
    for (int i = 0; i < 4; i++) xfer(1, 0, cola[i]);
    expect_sig("cola_line1",  SIG_LINE1,  line_of("COLA"));
    expect_sig("cola_cursor", SIG_CURSOR, 128'h04);
    xfer(0, 0, 8'hC0);
    xfer(1, 0, "A");
    expect_sig("row1_line2",  SIG_LINE2,  line_of("A"));
    expect_sig("row1_cursor", SIG_CURSOR, 128'h41);

    // Hidden address 0x27 then wrap into 0x40.
    xfer(0, 0, 8'hA7);
    xfer(1, 0, "X");
    xfer(1, 0, "Y");
    expect_sig("wrap_cursor", SIG_CURSOR, 128'h41);
    expect_sig("wrap_line2",  SIG_LINE2,  line_of("Y"));
    expect_sig("wrap_line1",  SIG_LINE1,  line_of("COLA"));

    // Cursor shifts across window boundaries; display shift is a no-op.
    xfer(0, 0, 8'h10);
    xfer(0, 0, 8'h10);
    expect_sig("shl_cursor", SIG_CURSOR, 128'h27);
    xfer(0, 0, 8'h14);
    xfer(0, 0, 8'h1C);
    expect_sig("shr_cursor", SIG_CURSOR, 128'h40);

    // CGRAM mode discards data; gap address remap.
    xfer(0, 0, 8'h40);
    xfer(1, 0, "Q");
    expect_sig("cg_cursor", SIG_CURSOR, 128'h40);
    expect_sig("cg_line2",  SIG_LINE2,  line_of("Y"));
    xfer(0, 0, 8'hB0);
    expect_sig("remap_hi", SIG_CURSOR, 128'h40);
    xfer(1, 0, "R");
    expect_sig("remap_line2", SIG_LINE2, line_of("R"));
    xfer(0, 0, 8'hE8);
    expect_sig("remap_lo", SIG_CURSOR, 128'h00);

    // Fill row 0, clear display, drop five transfers while busy.
    xfer(0, 0, 8'h80);
    for (int i = 0; i < 16; i++) xfer(1, 0, fill[i]);
    expect_sig("fill_line1",  SIG_LINE1,  line_of("abcdefghijklmnop"));
    expect_sig("fill_cursor", SIG_CURSOR, 128'h10);
    busy_q.push_back(36);
    xfer(0, 0, 8'h01);
    xfer(1, 0, "W");
    xfer(0, 0, 8'h80);
    xfer(0, 0, 8'h0C);
    xfer(0, 0, 8'h01);
    xfer(1, 0, "V");
    wait_idle();
    expect_sig("clr_line1",  SIG_LINE1,  line_of(""));
    expect_sig("clr_line2",  SIG_LINE2,  line_of(""));
    expect_sig("clr_drop",   SIG_DROP,   128'd5);
    expect_sig("clr_cursor", SIG_CURSOR, 128'h00);
    expect_sig("clr_flags",  SIG_FLAGS,  128'b11111);

    // Decrement mode wraps 0x00 to 0x67.
    xfer(0, 0, 8'h04);
    expect_sig("dec_flags", SIG_FLAGS, 128'b11110);
    xfer(0, 0, 8'h80);
    xfer(1, 0, "Z");
    expect_sig("dec_line1",  SIG_LINE1,  line_of("Z"));
    expect_sig("dec_cursor", SIG_CURSOR, 128'h67);

    // Reset in the middle of a clear.
    xfer(0, 0, 8'h01);
    repeat (10) @(posedge clk_100hz);
    #1 rst = 1'b0;
    expect_reset_state("midclr");
    repeat (2) @(posedge clk_100hz);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk_100hz);
    #1;
    expect_sig("post_rst_busy", SIG_BUSY, 128'd0);

    // Read transfers.
    xfer(0, 0, 8'hC3);
    expect_sig("rd_setup_cursor", SIG_CURSOR, 128'h43);
`ifdef LCD_READ_EN
    rd_q.push_back(8'h43);
    xfer(0, 1, 8'h00);
    rd_q.push_back(8'h20);
    xfer(1, 1, 8'h00);
    expect_sig("rd_cursor", SIG_CURSOR, 128'h44);
    busy_q.push_back(36);
    xfer(0, 0, 8'h01);
    rd_q.push_back(8'h80);
    xfer(0, 1, 8'h00);
    wait_idle();
    expect_sig("rd_busy_drop", SIG_DROP, 128'd0);
`else
    xfer(0, 1, 8'h00);
    xfer(1, 1, 8'h00);
    expect_sig("rd_ign_cursor", SIG_CURSOR,  128'h43);
    expect_sig("rd_ign_data",   SIG_RD_DATA, 128'd0);
    busy_q.push_back(36);
    xfer(0, 0, 8'h01);
    xfer(0, 1, 8'h00);
    wait_idle();
    expect_sig("rd_busy_drop", SIG_DROP, 128'd1);
`endif

    expect_sig("timeout", SIG_TIMEOUT, 128'd0);
    repeat (2) @(posedge clk_100hz);
    #1;
    expect_sig("pending", SIG_PENDING, 128'd0);
    repeat (2) @(posedge clk_100hz);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Responder end of the HD44780-style 8-bit text-LCD write bus driven by the vending machine's text-LCD writer.
- Decodes rs/rw/data transfers and maintains a 2x16 shadow DDRAM, address counter and display flags.
- Exposes the visible text in the same packed 16-character line format the writer consumes.
- Used as an on-board mirror and loopback checker; optionally services busy-flag and data reads.

Parameters:
- BLANK_CHAR, 8'h20: fill value for reset and clear-display.
- CLEAR_WAIT, 4: extra busy cycles after the clear sweep (0..15).

Ports:
- clk_100hz  in  1  bus clock; one transfer per cycle max
- rst  in  1  asynchronous, active-low reset
- bus_valid  in  1  transfer strobe; bus sampled at posedge when 1
- lcd_rs  in  1  0=instruction, 1=data
- lcd_rw  in  1  0=write, 1=read
- lcd_data  in  8  write payload
- rd_data  out  8  read response
- rd_oe  out  1  rd_data valid
- line1_text  out  128  row 0, char 0 in [127:120]
- line2_text  out  128  row 1, char 0 in [127:120]
- cursor_addr  out  7  address counter AC
- display_on, cursor_on, blink_on  out  1 each  display on/off D/C/B
- inc_mode  out  1  entry-mode I/D
- init_done  out  1  set by the first function set
- busy  out  1  clear in progress
- drop_cnt  out  8  transfers ignored while busy; saturates at 255

Behaviour:
- Reset values:
  - All 32 shadow cells = BLANK_CHAR; AC=0; inc_mode=1.
  - display_on, cursor_on, blink_on, init_done, busy, rd_oe = 0; rd_data=0; drop_cnt=0.
  - FSM enters S_IDLE.
- A reset mid-clear aborts the clear immediately.
- States:
  - S_IDLE: decodes transfers.
  - S_CLEAR: writes BLANK_CHAR to cell k on cycle k, k = 0..31, then goes to S_WAIT.
  - S_WAIT: counts CLEAR_WAIT cycles, then returns to S_IDLE; with CLEAR_WAIT=0 it goes directly to S_IDLE.
  - busy=1 in S_CLEAR and S_WAIT.
- While busy, bus_valid=1 transfers are ignored and increment drop_cnt (saturating). A busy-flag read is the exception (see Optional Feature).
- Instruction decode (rs=0, rw=0), highest set bit wins; all take effect the cycle after the sample:
  - 0x01: AC=0, inc_mode=1, go to S_CLEAR.
  - 0x02/0x03: AC=0.
  - 0x04-0x07: inc_mode=bit1; display-shift bit ignored.
  - 0x08-0x0F: display_on=bit2, cursor_on=bit1, blink_on=bit0.
  - 0x10-0x1F: if bit3=0, move AC by ±1 per bit2 with wrap; if bit3=1 (display shift), no effect.
  - 0x20-0x3F: init_done=1; other bits ignored.
  - 0x40-0x7F: CGRAM address set; sets cg_mode, and subsequent data writes are discarded without moving AC until the next DDRAM set or clear.
  - 0x80-0xFF: AC=data[6:0], cg_mode=0. Gap addresses are remapped: 0x28-0x3F -> 0x40, 0x68-0x7F -> 0x00.
- Data write (rs=1, rw=0, cg_mode=0):
  - AC 0x00-0x0F writes row 0 col AC; AC 0x40-0x4F writes row 1 col AC-0x40.
  - Other valid addresses (0x10-0x27, 0x50-0x67) store nothing but still advance AC.
- AC advance (inc/dec):
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
- line*_text and cursor_addr are registered and reflect a write one cycle after its sample edge.

Optional Feature:
- Macro LCD_READ_EN.
- Defined:
  - rw=1, rs=0: rd_data={busy, AC} with rd_oe=1 for the next cycle. Honored even while busy and not counted in drop_cnt.
  - rw=1, rs=0 while idle (busy=0): rd_data = 0, AC.
  - rw=1, rs=1, idle: rd_data = shadow cell at AC (BLANK_CHAR if AC is not visible), rd_oe=1 for the next cycle, then AC advances as for a write.
- Undefined:
  - All rw=1 transfers are ignored.
  - rd_oe and rd_data are held at 0.
  - A read while busy still increments drop_cnt.

Test Plan:
- Reset, then transfers 0x38, 0x0F, 0x06 (rs=0) -> init_done=1, display_on=cursor_on=blink_on=1, inc_mode=1, line1_text = 16 x 8'h20.
- 0x80, then rs=1 "COLA" -> line1_text[127:96]=0x434F4C41, cursor_addr=0x04; then 0xC0, 'A' -> line2_text[127:120]=0x41, cursor_addr=0x41.
- 0xA7, two data writes 'X','Y' -> no visible change, cursor_addr=0x41, line2_text[127:120]=0x59 ('Y' lands at 0x40).
- Fill row 0, send 0x01, drive 5 transfers during busy -> busy high exactly 32+CLEAR_WAIT=36 cycles, all cells = 0x20, drop_cnt=5, AC=0.
- Entry 0x04, 0x80, write 'Z' -> cell (0,0)='Z', cursor_addr=0x67; reset asserted mid-clear -> all outputs at reset values.
- With LCD_READ_EN: AC=0x43, rs=0/rw=1 read -> rd_oe=1, rd_data=0x43; read during clear -> rd_data[7]=1.
